// File: rtl/irq_ctl_if.sv
// CPU-side register bus for irq_ctl: address, write data, write enable,
// ready, and the registered read data returned to the CPU.
interface irq_ctl_if;
    logic [15:0] AD;
    logic [7:0]  DI;
    logic        WE;
    logic        RDY;
    logic [7:0]  DO;

    modport master (
        output AD,
        output DI,
        output WE,
        output RDY,
        input  DO
    );

    modport slave (
        input  AD,
        input  DI,
        input  WE,
        input  RDY,
        output DO
    );
endinterface

// File: rtl/irq_ctl.sv
// Interrupt controller: N synchronized sources, per-channel level/edge mode,
// polarity and mask, prioritized vector, and an 8-byte CPU register window.
module irq_ctl #(
    parameter int unsigned N    = 4,
    parameter logic [15:0] BASE = 16'hFE00
) (
    input  logic         clk,
    input  logic         RST,
    irq_ctl_if.slave     bus,
    input  logic [N-1:0] src,
    output logic         IRQ
);

    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd1;
    localparam logic [2:0] OFF_MODE = 3'd2;
    localparam logic [2:0] OFF_POL  = 3'd3;
    localparam logic [2:0] OFF_ACK  = 3'd4;
    localparam logic [2:0] OFF_VEC  = 3'd5;

    // State is kept 8 bits wide; bits N..7 are forced to zero by this mask.
    localparam logic [7:0] LIVE = 8'((1 << N) - 1);

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] hist_q,  hist_d;
    logic [7:0] pend_q,  pend_d;
    logic [7:0] mask_q,  mask_d;
    logic [7:0] mode_q,  mode_d;
    logic [7:0] pol_q,   pol_d;
    logic [7:0] do_q,    do_d;
    logic       irq_q,   irq_d;

    logic [7:0] src_ext;
    logic [7:0] di_live;
    logic [7:0] act;
    logic [7:0] rise;
    logic [7:0] ack_clr;
    logic [7:0] mode_arm;
    logic [7:0] masked;
    logic [7:0] vec;
    logic [7:0] rd_data;
    logic [2:0] off;
    logic       in_win;
    logic       wr_en;

    always_comb begin
        src_ext = '0;
        src_ext[N-1:0] = src;
    end

    assign di_live = bus.DI & LIVE;
    assign in_win  = (bus.AD[15:3] == BASE[15:3]);
    assign off     = bus.AD[2:0];
    assign wr_en   = bus.WE && bus.RDY && in_win;

    // Polarity is applied after the synchronizer, so a POL write takes effect
    // on the active level in the very next cycle.
    assign act    = (sync2_q ^ pol_q) & LIVE;
    assign rise   = act & ~hist_q;
    assign masked = pend_q & mask_q;

    always_comb begin
        vec = 8'h80;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                vec = {5'b0, i[2:0]};
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (in_win) begin
            case (off)
                OFF_PEND: rd_data = pend_q;
                OFF_MASK: rd_data = mask_q;
                OFF_MODE: rd_data = mode_q;
                OFF_POL:  rd_data = pol_q;
                OFF_VEC:  rd_data = vec;
                default:  rd_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        sync1_d  = src_ext & LIVE;
        sync2_d  = sync1_q;
        hist_d   = act;
        mask_d   = mask_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        ack_clr  = 8'h00;
        mode_arm = 8'h00;

        if (wr_en) begin
            case (off)
                OFF_MASK: mask_d  = di_live;
                OFF_MODE: begin
                    mode_d   = di_live;
                    mode_arm = di_live & ~mode_q;
                end
                OFF_POL:  pol_d   = di_live;
                OFF_ACK:  ack_clr = di_live;
                default:  ;
            endcase
        end

        // Edge channels: a new edge beats a simultaneous ACK.
        // Level channels simply register the active level.
        pend_d = (mode_q & (rise | (pend_q & ~ack_clr))) | (~mode_q & act);
        // Switching a channel into edge mode starts it clean.
        pend_d = pend_d & ~mode_arm & LIVE;

        irq_d = |masked;
        do_d  = bus.RDY ? rd_data : do_q;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            do_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            do_q    <= do_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.DO = do_q;
    assign IRQ    = irq_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed and randomized bench for irq_ctl (N=4) with a cycle-level
// behavioural reference model of the register map and interrupt rules.
module tb_irq_ctl;

    localparam int          NCH  = 4;
    localparam logic [15:0] BASE = 16'hFE00;
    localparam logic [7:0]  LIVE = 8'h0F;

    logic           clk = 1'b0;
    logic           RST = 1'b0;
    logic [NCH-1:0] src;
    logic           IRQ;

    irq_ctl_if bus ();

    irq_ctl #(.N(NCH), .BASE(BASE)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus),
        .src (src),
        .IRQ (IRQ)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: register file, the source value seen one and two
    // edges ago, and the active level seen on the previous edge.
    logic [7:0] m_mask, m_mode, m_pol, m_pend, m_do;
    logic       m_irq;
    logic [7:0] m_src1, m_src2, m_prev_a;

    task automatic model_reset();
        m_mask = 0; m_mode = 0; m_pol = 0; m_pend = 0; m_do = 0; m_irq = 0;
        m_src1 = 0; m_src2 = 0; m_prev_a = 0;
    endtask

    function automatic logic [7:0] model_view(input int o);
        logic [7:0] mk;
        logic [7:0] v;
        mk = m_pend & m_mask;
        v  = 8'h80;
        for (int i = NCH - 1; i >= 0; i--) if (mk[i]) v = 8'(i);
        case (o)
            0: return m_pend;
            1: return m_mask;
            2: return m_mode;
            3: return m_pol;
            5: return v;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] a, pn, di, s8;
        int  addr, o;
        bit  inwin, wr;
        addr  = int'(bus.AD);
        inwin = (addr >= int'(BASE)) && (addr < int'(BASE) + 8);
        o     = addr - int'(BASE);
        wr    = bus.WE && bus.RDY && inwin;
        di    = bus.DI & LIVE;
        s8    = 8'(src);
        a     = (m_src2 ^ m_pol) & LIVE;
        for (int i = 0; i < 8; i++) begin
            if (!m_mode[i])                    pn[i] = a[i];
            else if (a[i] && !m_prev_a[i])     pn[i] = 1'b1;
            else if (wr && o == 4 && di[i])    pn[i] = 1'b0;
            else                               pn[i] = m_pend[i];
        end
        if (wr && o == 2) pn = pn & ~(di & ~m_mode);
        m_irq = |(m_pend & m_mask);
        if (bus.RDY) m_do = inwin ? model_view(o) : 8'h00;
        if (wr) begin
            if (o == 1) m_mask = di;
            if (o == 2) m_mode = di;
            if (o == 3) m_pol  = di;
        end
        m_pend   = pn & LIVE;
        m_prev_a = a;
        m_src2   = m_src1;
        m_src1   = s8 & LIVE;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        #1;
        chk("rst_irq", {7'b0, IRQ}, 8'h00);
        chk("rst_do", bus.DO, 8'h00);
        @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic wr(input logic [2:0] o, input logic [7:0] d);
        bus.AD = BASE + 16'(o); bus.DI = d; bus.WE = 1'b1; bus.RDY = 1'b1;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic rd(input logic [2:0] o, input string tag, input logic [7:0] exp);
        bus.AD = BASE + 16'(o); bus.WE = 1'b0; bus.RDY = 1'b1;
        tick();
        chk(tag, bus.DO, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AD = BASE; bus.DI = 8'h00; bus.WE = 1'b0; bus.RDY = 1'b1;
        src = '0;
        model_reset();
        #2;
        do_reset();
        rd(1, "rst_mask", 8'h00);
        rd(2, "rst_mode", 8'h00);
        rd(3, "rst_pol",  8'h00);
        rd(0, "rst_pend", 8'h00);

        // Edge channel 0: four-cycle latency and sticky pending
        wr(1, 8'h0F);
        wr(2, 8'h01);
        bus.AD = BASE;
        src = 4'b0001;
        ticks(3);
        chk("irq_cycle3", {7'b0, IRQ}, 8'h00);
        src = 4'b0000;
        tick();
        chk("irq_cycle4", {7'b0, IRQ}, 8'h01);
        ticks(4);
        rd(0, "edge_pend_hold", 8'h01);
        chk("edge_irq_hold", {7'b0, IRQ}, 8'h01);
        rd(5, "edge_vec", 8'h00);

        wr(4, 8'h01);
        chk("irq_on_ack_edge", {7'b0, IRQ}, 8'h01);
        rd(0, "pend_after_ack", 8'h00);
        chk("irq_after_ack", {7'b0, IRQ}, 8'h00);

        src = 4'b0001; ticks(3);
        src = 4'b0000; ticks(3);
        src = 4'b0001; ticks(2);
        wr(4, 8'h01);
        rd(0, "set_beats_ack", 8'h01);
        src = 4'b0000; ticks(3);
        wr(4, 8'h01);
        rd(0, "ack_clears", 8'h00);

        // Level channel 1 with inverted polarity
        wr(2, 8'h00);
        wr(3, 8'h02);
        src = 4'b0010; ticks(4);
        rd(0, "lvl_inactive", 8'h00);
        src = 4'b0000; ticks(4);
        chk("lvl_irq", {7'b0, IRQ}, 8'h01);
        rd(0, "lvl_pend", 8'h02);
        rd(5, "lvl_vec", 8'h01);
        wr(4, 8'hFF);
        rd(0, "ack_on_level", 8'h02);

        // Priority and masking
        src = 4'b1100; ticks(4);
        wr(1, 8'h08);
        rd(5, "vec_mask08", 8'h03);
        wr(1, 8'h0C);
        rd(5, "vec_mask0c", 8'h02);
        wr(1, 8'h00);
        rd(5, "vec_mask00", 8'h80);
        chk("irq_mask00", {7'b0, IRQ}, 8'h00);
        rd(0, "pend_multi", 8'h0E);

        // Bus behaviour
        bus.AD = BASE + 16'd1; bus.DI = 8'hFF; bus.WE = 1'b1; bus.RDY = 1'b0;
        tick();
        chk("do_held_rdy0", bus.DO, 8'h0E);
        bus.WE = 1'b0; bus.RDY = 1'b1;
        rd(1, "mask_rdy0_write", 8'h00);
        wr(1, 8'hFF);
        rd(1, "mask_upper_bits", 8'h0F);
        rd(0, "pend_before_rsvd", 8'h0E);
        rd(7, "rsvd7", 8'h00);
        rd(0, "pend_before_below", 8'h0E);
        bus.AD = BASE - 16'd1;
        tick();
        chk("below_window", bus.DO, 8'h00);
        wr(6, 8'hFF);
        rd(6, "rsvd6", 8'h00);

        // Polarity change in edge mode counts as an edge
        wr(2, 8'h01);
        wr(3, 8'h03);
        tick();
        rd(0, "pol_edge", 8'h0F);
        wr(4, 8'h01);
        rd(0, "pol_edge_ack", 8'h0E);
        chk("irq_before_rst", {7'b0, IRQ}, 8'h01);

        // Reset in the middle of a MODE write
        bus.AD = BASE + 16'd2; bus.DI = 8'hFF; bus.WE = 1'b1; bus.RDY = 1'b1;
        src = 4'b0000;
        do_reset();
        bus.WE = 1'b0;
        rd(2, "mode_after_rst", 8'h00);
        rd(1, "mask_after_rst", 8'h00);
        rd(3, "pol_after_rst", 8'h00);
        rd(0, "pend_after_rst", 8'h00);

        // Randomized traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset();
            if ($urandom_range(0, 5) == 0) src = 4'($urandom);
            case ($urandom_range(0, 9))
                8:       bus.AD = BASE - 16'($urandom_range(1, 4));
                9:       bus.AD = BASE + 16'($urandom_range(8, 12));
                default: bus.AD = BASE + 16'($urandom_range(0, 7));
            endcase
            bus.DI  = 8'($urandom);
            bus.WE  = ($urandom_range(0, 3) == 0);
            bus.RDY = ($urandom_range(0, 4) != 0);
            tick();
            chk("rand_do", bus.DO, m_do);
            chk("rand_irq", {7'b0, IRQ}, {7'b0, m_irq});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 Parameter N, default 4, number of interrupt source channels, legal range 1..8.
REQ-002 Parameter BASE, default 16'hFE00, base address of the 8-byte register window, aligned to 8.
REQ-003 clk  input  1  CPU clock, all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 AD  input  16  CPU address bus, combinatorial from CPU.
REQ-006 DI  input  8  write data, from CPU DO.
REQ-007 WE  input  1  CPU write enable.
REQ-008 RDY  input  1  CPU ready; when 0 the block holds all bus-side state.
REQ-009 DO  output  8  registered read data, to CPU DI mux.
REQ-010 src  input  N  asynchronous interrupt sources.
REQ-011 IRQ  output  1  registered active-high interrupt request to CPU.

Function
REQ-012 Registers at BASE+offset: 0 PEND (R), 1 MASK (R/W), 2 MODE (R/W, 1=edge, 0=level), 3 POL (R/W, 1=active-low), 4 ACK (W, write-1-to-clear), 5 VEC (R), 6-7 reserved (read 0, writes ignored).
REQ-013 Bits N..7 of every register read as 0 and ignore writes.
REQ-014 Each src bit passes a 2-flop synchronizer; active level a[i] = sync2[i] XOR POL[i].
REQ-015 A register write occurs on a clock edge with WE=1, RDY=1, AD in window.
REQ-016 Read latency is one cycle: when RDY=1, DO loads the value addressed by AD in the same cycle; AD outside window loads DO=0; when RDY=0 DO holds.
REQ-017 Reads have no side effects on any state.
REQ-018 Level channel (MODE[i]=0): PEND[i] equals a[i] registered, one cycle after sync2.
REQ-019 Edge channel (MODE[i]=1): PEND[i] sets when a[i]=1 and previous a[i]=0; stays set until ACK write with DI[i]=1.
REQ-020 Edge set and ACK clear on the same edge: set wins, PEND[i] stays 1.
REQ-021 ACK on a level channel has no effect.
REQ-022 Writing MODE from 1 to 0 hands PEND[i] to level tracking on the next edge; writing MODE from 0 to 1 clears PEND[i] and the previous-a history restarts at current a[i] (no spurious edge).
REQ-023 Writing POL changes a[i] immediately; in edge mode a resulting 0->1 transition of a[i] counts as an edge.
REQ-024 IRQ is registered: IRQ <= |(PEND & MASK), one cycle after PEND; IRQ updates regardless of RDY.
REQ-025 VEC = {1'b0, 4'b0, idx[2:0]} of lowest-numbered set bit of PEND & MASK; 8'h80 when none.
REQ-026 Source-to-IRQ latency: src edge to IRQ high = 4 clk cycles (2 sync, 1 PEND, 1 IRQ).
REQ-027 RDY=0 does not block synchronizer, PEND, or edge detection; only bus writes and DO are held.

Reset
REQ-028 RST=1 asynchronously forces: MASK=0, MODE=0, POL=0, PEND=0, synchronizers=0, edge history=0, DO=8'h00, IRQ=0.
REQ-029 After RST deasserts, first edge history sample takes current a; an already-asserted source does not produce an edge event.
REQ-030 RST asserted mid-write or mid-read aborts the access; no partial register update.

Verification
REQ-031 N=4: write MASK=8'h0F, MODE=8'h01; pulse src[0] high 3 cycles -> IRQ=1 at cycle 4 after rise, PEND=8'h01 persists after src falls, VEC reads 8'h00.
REQ-032 Continue: write ACK=8'h01 -> PEND=0 next cycle, IRQ=0 following cycle; repeat with src[0] rising on the ACK edge -> PEND stays 8'h01.
REQ-033 Level: MODE=0, POL=8'h02, src[1]=1 then 0 -> PEND[1]=0 while src=1, PEND[1]=1 and IRQ=1 after src=0; VEC=8'h01.
REQ-034 Priority/mask: src[3] and src[2] pending level, MASK=8'h08 -> VEC=8'h03; MASK=8'h0C -> VEC=8'h02; MASK=0 -> VEC=8'h80, IRQ=0.
REQ-035 Bus: RDY=0 with WE=1 to MASK -> MASK unchanged, DO held; read of BASE+7 and of BASE-1 -> DO=8'h00; RST mid-sequence -> all registers 0 immediately.
